// File: rtl/nibble_mem_pkg.sv
// Shared definitions for the nibble memory server: FSM encodings, size defaults
// and the reset image used when NIBBLE_MEM_PRELOAD_EN is defined.
package nibble_mem_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 16;
  localparam int unsigned DATA_W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  localparam logic [15:0][3:0] PRELOAD_IMAGE = {{14{4'hF}}, 4'h2, 4'h1};

  // Entries beyond the 16-word image read as erased (4'hF).
  function automatic logic [3:0] preload_word(input int unsigned idx);
    if (idx < 16) return PRELOAD_IMAGE[idx[3:0]];
    else          return 4'hF;
  endfunction

endpackage

// File: rtl/nms_regfile.sv
// Flop-based register file: one write port, registered read port, reset image
// taken from PRELOAD_IMAGE when NIBBLE_MEM_PRELOAD_EN is defined, else zeros.
module nms_regfile
  import nibble_mem_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned WIDTH = DATA_W_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Read returns the pre-write contents, so a same-cycle write is not forwarded.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef NIBBLE_MEM_PRELOAD_EN
        mem_q[i] <= WIDTH'(preload_word(i));
`else
        mem_q[i] <= '0;
`endif
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nibble_mem_server.sv
// Nibble memory server: serve mode reads a 16x4 store, load mode fills it
// sequentially on strobe edges. Optional macro: NIBBLE_MEM_PRELOAD_EN.
module nibble_mem_server
  import nibble_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic       clk, rst, mode, strobe;
  logic [3:0] nib;

  assign clk    = io_in[0];
  assign rst    = io_in[1];
  assign mode   = io_in[2];
  assign strobe = io_in[3];
  assign nib    = io_in[7:4];

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic              strobe_q, strobe_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic              we;
  logic              strobe_edge;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        data_out;

  assign strobe_edge = strobe & ~strobe_q;

  nms_regfile #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr_q),
    .wdata (DATA_W'(nib)),
    .raddr (AW'(nib)),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SERVE;
      wptr_q     <= '0;
      strobe_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      strobe_q   <= strobe_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Leaving LOAD/FULL on mode=0 outranks a same-cycle strobe edge.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    we       = 1'b0;
    strobe_d = strobe;
    case (state_q)
      ST_SERVE: begin
        if (mode) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (!mode) begin
          state_d = ST_SERVE;
        end else if (strobe_edge) begin
          we = 1'b1;
          if (wptr_q == AW'(MEM_DEPTH - 1)) state_d = ST_FULL;
          else                              wptr_d  = wptr_q + 1'b1;
        end
      end
      ST_FULL: begin
        if (!mode) state_d = ST_SERVE;
      end
      default: state_d = ST_SERVE;
    endcase
    wr_ack_d   = we;
    // Valid only once the read address was itself sampled in SERVE.
    rd_valid_d = (state_q == ST_SERVE) && (state_d == ST_SERVE);
  end

  always_comb begin
    data_out = '0;
    case (state_q)
      ST_SERVE: data_out = 4'(rdata);
      ST_LOAD:  data_out = 4'(wptr_q);
      ST_FULL:  data_out = 4'hF;
      default:  data_out = '0;
    endcase
    io_out = {state_q, rd_valid_q, wr_ack_q, data_out};
  end

endmodule
